// File: rtl/rv32i_alu_core.sv
// Purpose: RV32I execute-stage integer ALU with a registered copy for the next stage; optional multiply ops under `RV32I_ALU_MUL_EN`.
// Latency: result/zero are combinational (0 cycles); result_q/zero_q/out_valid are registered (1 cycle).
// Backpressure: none; there is no ready, and the register captures on every edge where in_valid is high and holds otherwise.
module rv32i_alu_core #(
    parameter int               XLEN           = 32,
    parameter logic [XLEN-1:0]  DEFAULT_RESULT = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [XLEN-1:0] result_q,
    output logic            zero_q,
    output logic            out_valid
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_PASSB = 4'b1010;

    // Only the low five bits of b select a shift distance; the rest are ignored.
    logic [4:0] shamt;
    assign shamt = b[4:0];

`ifdef RV32I_ALU_MUL_EN
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_MULHU = 4'b1100;
    localparam logic [3:0] OP_MULH  = 4'b1101;

    // One shared multiplier: operands are sign-extended only for MULH, so the
    // low half serves MUL and the high half serves both MULHU and MULH.
    logic                a_sx;
    logic                b_sx;
    logic [2*XLEN-1:0]   prod;

    // Select sign or zero extension of the multiplier operands.
    always_comb begin
        a_sx = (op == OP_MULH) && a[XLEN-1];
        b_sx = (op == OP_MULH) && b[XLEN-1];
    end

    assign prod = {{XLEN{a_sx}}, a} * {{XLEN{b_sx}}, b};
`endif

    // Opcode decode and combinational result; reset has no effect here.
    always_comb begin
        result = DEFAULT_RESULT;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_SRA:   result = $signed(a) >>> shamt;
            OP_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
            OP_PASSB: result = b;
`ifdef RV32I_ALU_MUL_EN
            OP_MUL:   result = prod[XLEN-1:0];
            OP_MULHU: result = prod[2*XLEN-1:XLEN];
            OP_MULH:  result = prod[2*XLEN-1:XLEN];
`endif
            default:  result = DEFAULT_RESULT;
        endcase
    end

    assign zero = (result == '0);

    // Pipeline register: valid always follows in_valid, data only updates on valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q  <= '0;
            zero_q    <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result_q <= result;
                zero_q   <= zero;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_alu_core.sv
// Directed-vector bench for rv32i_alu_core: combinational result, registered stage, hold and reset.
module tb_rv32i_alu_core;

    logic        clk;
    logic        clk_en;
    logic        rst;
    logic        in_valid;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        zero;
    logic [31:0] result_q;
    logic        zero_q;
    logic        out_valid;

    int tests_run = 0;
    int tests_failed = 0;

    rv32i_alu_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .op        (op),
        .a         (a),
        .b         (b),
        .result    (result),
        .zero      (zero),
        .result_q  (result_q),
        .zero_q    (zero_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = clk_en ? ~clk : 1'b0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one valid operation, check the combinational result, then the registered copy.
    task automatic alu_step(input string tag, input logic [3:0] o, input logic [31:0] va,
                            input logic [31:0] vb, input logic [31:0] exp_res, input logic exp_zero);
        @(negedge clk);
        in_valid = 1'b1;
        op = o;
        a = va;
        b = vb;
        #1;
        check({tag, "_result"}, result, exp_res);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_zero});
        @(posedge clk);
        #1;
        check({tag, "_result_q"}, result_q, exp_res);
        check({tag, "_zero_q"}, {31'b0, zero_q}, {31'b0, exp_zero});
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        clk_en   = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'b0000;
        a        = 32'd0;
        b        = 32'd0;

        // Reset with no clock edges at all.
        #2;
        check("rst_result_q", result_q, 32'h0);
        check("rst_zero_q", {31'b0, zero_q}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);

        // Release reset; combinational path answers before any edge.
        rst = 1'b0;
        #2;
        in_valid = 1'b1;
        op = 4'b0000;
        a = 32'd10;
        b = 32'd20;
        #1;
        check("first_add_result", result, 32'd30);
        check("first_add_result_q_pre_edge", result_q, 32'h0);
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        check("first_add_result_q", result_q, 32'd30);
        check("first_add_out_valid", {31'b0, out_valid}, 32'd1);
        check("first_add_zero_q", {31'b0, zero_q}, 32'd0);

        // Logic ops.
        alu_step("and", 4'b0010, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1'b0);
        alu_step("or",  4'b0011, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FFF0FFF, 1'b0);
        alu_step("xor", 4'b0100, 32'h0F0F0F0F, 32'h00FF00FF, 32'h0FF00FF0, 1'b0);

        // Arithmetic and wrap-around.
        alu_step("sub_ovf", 4'b0001, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
        alu_step("sub_eq",  4'b0001, 32'd5, 32'd5, 32'h0, 1'b1);
        alu_step("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1);
        alu_step("add_sign", 4'b0000, 32'h7FFFFFFF, 32'd1, 32'h80000000, 1'b0);
        alu_step("sub", 4'b0001, 32'd30, 32'd10, 32'd20, 1'b0);

        // Hold: in_valid low keeps the registered data, drops out_valid.
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'b0000;
        a = 32'd1;
        b = 32'd1;
        #1;
        check("hold_result", result, 32'd2);
        @(posedge clk);
        #1;
        check("hold_result_q", result_q, 32'd20);
        check("hold_zero_q", {31'b0, zero_q}, 32'd0);
        check("hold_out_valid", {31'b0, out_valid}, 32'd0);

        // Shifts: upper bits of b ignored, shift amount 4.
        alu_step("sll", 4'b0101, 32'h80000000, 32'hFFFFFFE4, 32'h00000000, 1'b1);
        alu_step("srl", 4'b0110, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0);
        alu_step("sra", 4'b0111, 32'h80000000, 32'hFFFFFFE4, 32'hF8000000, 1'b0);
        alu_step("sra31", 4'b0111, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b0);
        alu_step("sra_pos", 4'b0111, 32'h40000000, 32'd2, 32'h10000000, 1'b0);
        alu_step("sll0", 4'b0101, 32'h12345678, 32'h00000020, 32'h12345678, 1'b0);
        alu_step("srl0", 4'b0110, 32'h87654321, 32'd0, 32'h87654321, 1'b0);
        alu_step("sll3", 4'b0101, 32'h00000011, 32'd3, 32'h00000088, 1'b0);

        // Compares and pass-through.
        alu_step("slt_neg", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        alu_step("sltu_big", 4'b1001, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        alu_step("slt_min", 4'b1000, 32'h80000000, 32'd0, 32'd1, 1'b0);
        alu_step("sltu_min", 4'b1001, 32'h80000000, 32'd0, 32'd0, 1'b1);
        alu_step("slt_ge", 4'b1000, 32'd7, 32'd7, 32'd0, 1'b1);
        alu_step("sltu_lt", 4'b1001, 32'd3, 32'd9, 32'd1, 1'b0);
        alu_step("passb", 4'b1010, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        alu_step("op1111", 4'b1111, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b1);
        alu_step("op1110", 4'b1110, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b1);

`ifdef RV32I_ALU_MUL_EN
        alu_step("mul", 4'b1011, 32'h00010000, 32'h00010000, 32'h0, 1'b1);
        alu_step("mulhu", 4'b1100, 32'h00010000, 32'h00010000, 32'd1, 1'b0);
        alu_step("mul_small", 4'b1011, 32'd6, 32'd7, 32'd42, 1'b0);
        alu_step("mulhu_max", 4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        alu_step("mulh_m1", 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
        alu_step("mulh_neg", 4'b1101, 32'h80000000, 32'd2, 32'hFFFFFFFF, 1'b0);
`else
        alu_step("op1011", 4'b1011, 32'h00010000, 32'h00010000, 32'h0, 1'b1);
        alu_step("op1100", 4'b1100, 32'h00010000, 32'h00010000, 32'h0, 1'b1);
        alu_step("op1101", 4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
`endif

        // Reset in the middle of operation: registered value discarded at once.
        alu_step("pre_rst_add", 4'b0000, 32'd3, 32'd4, 32'd7, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_result_q", result_q, 32'h0);
        check("midrst_zero_q", {31'b0, zero_q}, 32'd1);
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_comb_result", result, 32'd7);
        @(posedge clk);
        #1;
        check("midrst_held_result_q", result_q, 32'h0);
        check("midrst_held_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("postrst_result_q", result_q, 32'd7);
        check("postrst_out_valid", {31'b0, out_valid}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
